wb_dual_master_arbiter: RTL
===========================

Name: wb_dual_master_arbiter

Overview:
- Shares one external Wishbone bus between the CPU core's instruction master (I) and data master (D).
- Sits between the core's two wishbone_bus_if instances and the single SoC slave interconnect.
- Grants one master at a time and holds the grant for the master's whole cyc.
- Arbitration is fixed-priority (D first) or round-robin, selected by parameter.
- A watchdog terminates any granted access the slave never acknowledges, with an error strobe.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; sel width is DATA_W/8.
- RR, 0, 0 = fixed priority (D over I); 1 = round-robin (last-served master loses ties).
- TIMEOUT, 255, cycles without ack before the watchdog aborts. 0 disables the watchdog. Max 65535.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- d_addr_i  in  ADDR_W  D master address.
- d_data_i  in  DATA_W  D master write data.
- d_we_i  in  1  D master write enable.
- d_sel_i  in  DATA_W/8  D master byte selects.
- d_stb_i  in  1  D master strobe.
- d_cyc_i  in  1  D master cycle.
- d_data_o  out  DATA_W  read data to D.
- d_ack_o  out  1  ack to D.
- d_err_o  out  1  watchdog abort to D.
- i_addr_i, i_data_i, i_we_i, i_sel_i, i_stb_i, i_cyc_i  in  as D  I master request.
- i_data_o, i_ack_o, i_err_o  out  as D  I master response.
- s_addr_o  out  ADDR_W  slave address.
- s_data_o  out  DATA_W  slave write data.
- s_we_o  out  1  slave write enable.
- s_sel_o  out  DATA_W/8  slave byte selects.
- s_stb_o  out  1  slave strobe.
- s_cyc_o  out  1  slave cycle.
- s_data_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave ack.
- gnt_o  out  2  current grant, one-hot: bit1 = D, bit0 = I, 00 = idle.

Behaviour:
- FSM states: IDLE, GNT_D, GNT_I. State is registered and updated on the rising edge of clk.
- Reset: state = IDLE, RR last-served pointer = I (so D wins the first tie), watchdog counter = 0, err pulses = 0.
- Reset outputs: all s_*_o = 0, all ack/err = 0, gnt_o = 00, d_data_o/i_data_o = 0.
- Reset mid-transfer: abort immediately. Outputs drop the cycle after rst is sampled high; no ack or err is generated.
- IDLE transitions: arbitrate on sampled d_cyc_i and i_cyc_i.
  - Only one requests: grant it next cycle.
  - Both request, RR=0: grant D.
  - Both request, RR=1: grant the master that was not last served.
  - Arbitration latency: 1 cycle from cyc to the slave seeing cyc.
- In GNT_x: s_* outputs are a combinational mux of master x's request signals.
  - x_ack_o = s_ack_i & x_cyc_i.
  - x_data_o = s_data_i; the non-granted master's data_o = 0.
  - The non-granted master's ack and err are 0.
- Release: when x_cyc_i is sampled low in GNT_x, go to IDLE and update the last-served pointer to x.
  - One mandatory idle cycle (s_cyc_o = 0) separates any two grants. This holds even if the other master has been waiting.
- Mux rule: s_* outputs = 0 whenever state is IDLE or a watchdog abort is in progress.
- Watchdog counter (16 bits):
  - Cleared in IDLE, on s_ack_i = 1, or when the granted master's stb is low.
  - Otherwise increments each cycle in GNT_x while x_stb_i = 1.
  - When the counter equals TIMEOUT with s_ack_i still 0: assert x_err_o for exactly 1 cycle and force s_stb_o/s_cyc_o to 0 in that cycle.
  - Then go to IDLE and update the last-served pointer.
  - The master must drop cyc after err. If it holds cyc, it is re-arbitrated from IDLE like a new request.
- Simultaneous ack and timeout in the same cycle: ack wins, no err, counter clears.
- Back-to-back strobes within one cyc: the grant is kept. Each ack is passed through individually; there is no burst limit.
- A request raised by the non-granted master during a grant is only recorded in arbitration at the next IDLE cycle. Its stb/cyc never reach the slave early.
- No combinational path from s_ack_i to any s_* output.

Test Plan:
- Single D read: d_cyc/d_stb with addr 0x8000_0010, slave acks 2 cycles later with 0xDEADBEEF -> gnt_o = 10 one cycle after cyc; d_ack_o and d_data_o = 0xDEADBEEF in the ack cycle; i_ack_o = 0 throughout.
- Tie, RR=0: I and D raise cyc in the same cycle -> D granted first. After D drops cyc, exactly 1 idle cycle, then gnt_o = 01.
- Tie, RR=1, both masters holding continuous requests: grants alternate D, I, D, I, each separated by one s_cyc_o = 0 cycle.
- Watchdog, TIMEOUT=4: I strobes and the slave never acks -> i_err_o pulses once on the cycle the counter reaches 4; s_cyc_o = 0 that cycle; state returns to IDLE; i_ack_o never asserted.
- Ack/timeout collision, TIMEOUT=4: slave ack arrives exactly on the timeout cycle -> ack delivered, no err, transfer completes normally.
- Reset mid-transfer: rst asserted while GNT_D with stb high -> next cycle all s_*_o = 0, gnt_o = 00, no ack or err. After rst is released, a pending I request is granted in 1 cycle.

Source files
------------

// File: rtl/wb_dual_master_arbiter.sv
// Two-master Wishbone arbiter: data (D) and instruction (I) masters share one slave port.
// Grant is held for a master's whole cyc; a watchdog aborts accesses the slave never acknowledges.
module wb_dual_master_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR      = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_data_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_sel_i,
    input  logic                d_stb_i,
    input  logic                d_cyc_i,
    output logic [DATA_W-1:0]   d_data_o,
    output logic                d_ack_o,
    output logic                d_err_o,
    input  logic [ADDR_W-1:0]   i_addr_i,
    input  logic [DATA_W-1:0]   i_data_i,
    input  logic                i_we_i,
    input  logic [DATA_W/8-1:0] i_sel_i,
    input  logic                i_stb_i,
    input  logic                i_cyc_i,
    output logic [DATA_W-1:0]   i_data_o,
    output logic                i_ack_o,
    output logic                i_err_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_data_o,
    output logic                s_we_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    output logic                s_stb_o,
    output logic                s_cyc_o,
    input  logic [DATA_W-1:0]   s_data_i,
    input  logic                s_ack_i,
    output logic [1:0]          gnt_o
);

    typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;

    state_t      r_state;
    logic        r_last_d;
    logic [15:0] r_cnt;

    logic w_gnt_d;
    logic w_gnt_i;
    logic w_req_stb;
    logic w_req_cyc;
    logic w_timeout;
    logic w_abort;

    assign w_gnt_d   = (r_state == GNT_D);
    assign w_gnt_i   = (r_state == GNT_I);
    assign w_req_stb = (w_gnt_d && d_stb_i) || (w_gnt_i && i_stb_i);
    assign w_req_cyc = (w_gnt_d && d_cyc_i) || (w_gnt_i && i_cyc_i);

    // Timeout masking of the slave bus must not depend on s_ack_i; only err/state do.
    assign w_timeout = (TIMEOUT != 0) && w_req_stb && (r_cnt == 16'(TIMEOUT));
    assign w_abort   = w_timeout && !s_ack_i;

    assign gnt_o    = {w_gnt_d, w_gnt_i};
    assign d_ack_o  = w_gnt_d && s_ack_i && d_cyc_i;
    assign i_ack_o  = w_gnt_i && s_ack_i && i_cyc_i;
    assign d_err_o  = w_gnt_d && w_abort;
    assign i_err_o  = w_gnt_i && w_abort;
    assign d_data_o = w_gnt_d ? s_data_i : '0;
    assign i_data_o = w_gnt_i ? s_data_i : '0;

    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        if (w_gnt_d && !w_timeout) begin
            s_addr_o = d_addr_i;
            s_data_o = d_data_i;
            s_we_o   = d_we_i;
            s_sel_o  = d_sel_i;
            s_stb_o  = d_stb_i;
            s_cyc_o  = d_cyc_i;
        end else if (w_gnt_i && !w_timeout) begin
            s_addr_o = i_addr_i;
            s_data_o = i_data_i;
            s_we_o   = i_we_i;
            s_sel_o  = i_sel_i;
            s_stb_o  = i_stb_i;
            s_cyc_o  = i_cyc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (d_cyc_i && i_cyc_i) begin
                        r_state <= ((RR != 0) && r_last_d) ? GNT_I : GNT_D;
                    end else if (d_cyc_i) begin
                        r_state <= GNT_D;
                    end else if (i_cyc_i) begin
                        r_state <= GNT_I;
                    end
                end
                GNT_D, GNT_I: begin
                    // Every grant ends through IDLE, which yields the mandatory idle cycle.
                    if (!w_req_cyc || w_abort) begin
                        r_state  <= IDLE;
                        r_last_d <= w_gnt_d;
                        r_cnt    <= '0;
                    end else if (s_ack_i || !w_req_stb) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
